esi_cosim_mmio_responder: RTL and testbench



---
 rtl/esi_cosim_mmio_pkg.sv | 25 ++
 rtl/esi_cosim_mmio_resp_fifo.sv | 63 ++++++
 rtl/esi_cosim_mmio_responder.sv | 135 +++++++++++++
 tb/tb_esi_cosim_mmio_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/esi_cosim_mmio_pkg.sv
// Shared types and error codes for the cosim MMIO responder.
package esi_cosim_mmio_pkg;

  localparam int unsigned MMIO_ADDR_W = 32;
  localparam int unsigned MMIO_DATA_W = 32;
  localparam int unsigned MMIO_ERR_W  = 8;

  localparam logic [MMIO_ERR_W-1:0] MMIO_OK            = 8'd0;
  localparam logic [MMIO_ERR_W-1:0] MMIO_ERR_UNALIGNED = 8'd1;
  localparam logic [MMIO_ERR_W-1:0] MMIO_ERR_RANGE     = 8'd2;
  localparam logic [MMIO_ERR_W-1:0] MMIO_ERR_RO        = 8'd3;

  typedef struct packed {
    logic                   write;
    logic [MMIO_ADDR_W-1:0] address;
    logic [MMIO_DATA_W-1:0] data;
  } mmio_cmd_t;

  typedef struct packed {
    logic                   write;
    logic [MMIO_DATA_W-1:0] data;
    logic [MMIO_ERR_W-1:0]  error;
  } mmio_resp_t;

endpackage

// File: rtl/esi_cosim_mmio_resp_fifo.sv
// In-order response FIFO; DEPTH must be a power of two so pointers wrap naturally.
module esi_cosim_mmio_resp_fifo
  import esi_cosim_mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  mmio_resp_t       push_data_i,
  input  logic             pop_i,
  output mmio_resp_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  mmio_resp_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/esi_cosim_mmio_responder.sv
// MMIO target executing in-order commands against a small register file.
// Define ESI_COSIM_MMIO_RESPONDER_STATS_EN to add read/write counters after the last register.
module esi_cosim_mmio_responder
  import esi_cosim_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'hE51C_0001,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_write,
  output logic [31:0] resp_data,
  output logic [7:0]  resp_error
);

  localparam int unsigned IDX_W   = $clog2(NUM_REGS);
  localparam int unsigned CNT_W   = $clog2(RESP_DEPTH + 1);
  localparam logic [29:0] NREGS_W = 30'(NUM_REGS);

  mmio_cmd_t        cmd;
  mmio_resp_t       resp_d;
  mmio_resp_t       head;
  logic [29:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             below_base, in_regs, fire, wr_en;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];

  assign cmd        = '{write: cmd_write, address: cmd_address, data: cmd_data};
  assign cmd_ready  = !rst && !fifo_full;
  assign fire       = cmd_valid && cmd_ready;
  // BASE_ADDR is word aligned, so subtracting word indices equals the byte difference >> 2.
  assign offset     = cmd.address[31:2] - BASE_ADDR[31:2];
  assign below_base = (cmd.address < BASE_ADDR);
  assign in_regs    = !below_base && (offset < NREGS_W);
  assign idx        = offset[IDX_W-1:0];

`ifdef ESI_COSIM_MMIO_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        rd_cnt_hit, wr_cnt_hit;

  assign rd_cnt_hit = !below_base && (offset == NREGS_W);
  assign wr_cnt_hit = !below_base && (offset == NREGS_W + 30'd1);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (fire && !cmd.write) rd_cnt_d = rd_cnt_q + 32'd1;
    if (fire && cmd.write)  wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
`endif

  // Decode in priority order: alignment, range, read-only.
  always_comb begin
    resp_d       = '0;
    resp_d.write = cmd.write;
    if (cmd.address[1:0] != 2'b00) begin
      resp_d.error = MMIO_ERR_UNALIGNED;
`ifdef ESI_COSIM_MMIO_RESPONDER_STATS_EN
    end else if (rd_cnt_hit || wr_cnt_hit) begin
      if (cmd.write) resp_d.error = MMIO_ERR_RO;
      else           resp_d.data  = rd_cnt_hit ? rd_cnt_q : wr_cnt_q;
`endif
    end else if (!in_regs) begin
      resp_d.error = MMIO_ERR_RANGE;
    end else if (cmd.write && (idx == '0)) begin
      resp_d.error = MMIO_ERR_RO;
    end else if (!cmd.write) begin
      resp_d.data = regs_q[idx];
    end
  end

  assign wr_en = fire && cmd.write && in_regs && (resp_d.error == MMIO_OK);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[idx] = cmd.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      regs_q[0] <= ID_VALUE;
    end else begin
      regs_q <= regs_d;
    end
  end

  esi_cosim_mmio_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fire),
    .push_data_i(resp_d),
    .pop_i      (resp_ready),
    .head_o     (head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_empty == (fifo_count == '0));
  end

  // Idle outputs read as zero rather than exposing stale FIFO contents.
  assign resp_valid = !fifo_empty;
  assign resp_write = resp_valid && head.write;
  assign resp_data  = resp_valid ? head.data  : '0;
  assign resp_error = resp_valid ? head.error : '0;

endmodule

// File: tb/tb_esi_cosim_mmio_responder.sv
// Directed bench for esi_cosim_mmio_responder with a queue-based reference model.
module tb_esi_cosim_mmio_responder;

  localparam int          NREGS = 8;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] ID    = 32'hE51C_0001;
`ifdef ESI_COSIM_MMIO_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_address, cmd_data;
  logic        resp_valid, resp_ready, resp_write;
  logic [31:0] resp_data;
  logic [7:0]  resp_error;

  int vectors = 0;
  int miscompares = 0;

  logic [40:0] exp_q [$];
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_rd, m_wr;
  bit          m_push, m_pop;

  esi_cosim_mmio_responder #(
    .BASE_ADDR(BASE), .NUM_REGS(NREGS), .ID_VALUE(ID), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_data(resp_data), .resp_error(resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Executes one accepted command against the model state; returns {write, data, error}.
  function automatic logic [40:0] respond(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  err;
    logic [31:0] rd;
    longint      off;
    int          i;
    err = 8'd0;
    rd  = 32'd0;
    if (a % 4 != 0) err = 8'd1;
    else if (a < BASE) err = 8'd2;
    else begin
      off = (longint'(a) - longint'(BASE)) / 4;
      i   = int'(off);
      if (off < NREGS) begin
        if (w) begin
          if (off == 0) err = 8'd3;
          else m_regs[i] = d;
        end else rd = m_regs[i];
      end else if (STATS && off == NREGS) begin
        if (w) err = 8'd3; else rd = m_rd;
      end else if (STATS && off == NREGS + 1) begin
        if (w) err = 8'd3; else rd = m_wr;
      end else err = 8'd2;
    end
    if (w) m_wr = m_wr + 32'd1;
    else   m_rd = m_rd + 32'd1;
    return {w, (w || err != 0) ? 32'd0 : rd, err};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
      m_regs[0] = ID;
      m_rd = 32'd0;
      m_wr = 32'd0;
    end else begin
      m_push = cmd_valid && (exp_q.size() < DEPTH);
      m_pop  = resp_ready && (exp_q.size() > 0);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(respond(cmd_write, cmd_address, cmd_data));
    end
  end

  always @(negedge clk) begin
    check("cmd_ready", 64'(cmd_ready), 64'(!rst && exp_q.size() < DEPTH));
    check("resp_valid", 64'(resp_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      check("resp_payload", 64'({resp_write, resp_data, resp_error}), 64'(exp_q[0]));
    else if (rst)
      check("reset_payload", 64'({resp_write, resp_data, resp_error}), 64'(0));
  end

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_address = 32'd0;
    cmd_data = 32'd0;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_address = a;
    cmd_data = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for address %h", a);
    end
  endtask

  task automatic check_head(input string name, input logic w, input logic [31:0] d, input logic [7:0] e);
    @(negedge clk);
    check(name, 64'({resp_valid, resp_write, resp_data, resp_error}), 64'({1'b1, w, d, e}));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send(1'b0, 32'h0, 32'h0);
    idle();
    check_head("id_read", 1'b0, ID, 8'd0);

    send(1'b1, 32'h4, 32'hDEAD_BEEF);
    send(1'b0, 32'h4, 32'h0);
    idle();
    check_head("write_then_read", 1'b0, 32'hDEAD_BEEF, 8'd0);

    send(1'b0, 32'h6, 32'h0);
    idle();
    check_head("err_unaligned", 1'b0, 32'h0, 8'd1);
    send(1'b0, STATS ? 32'h28 : 32'h20, 32'h0);
    idle();
    check_head("err_range", 1'b0, 32'h0, 8'd2);
    send(1'b0, 32'h1000_0000, 32'h0);
    idle();
    check_head("err_range_far", 1'b0, 32'h0, 8'd2);
    send(1'b1, 32'h0, 32'h5);
    idle();
    check_head("err_readonly", 1'b1, 32'h0, 8'd3);
    send(1'b0, 32'h0, 32'h0);
    idle();
    check_head("id_intact", 1'b0, ID, 8'd0);

    send(1'b1, 32'h8, 32'h0000_0088);
    send(1'b1, 32'hC, 32'h0000_00CC);
    idle();
    repeat (3) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    send(1'b0, 32'h0, 32'h0);
    send(1'b0, 32'h4, 32'h0);
    send(1'b0, 32'h8, 32'h0);
    send(1'b0, 32'hC, 32'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_address = 32'h10;
    @(negedge clk);
    check("full_blocks_cmd", 64'(cmd_ready), 64'(0));
    check("full_head", 64'({resp_valid, resp_write, resp_data, resp_error}), 64'({1'b1, 1'b0, ID, 8'd0}));
    resp_ready = 1'b1;
    send(1'b0, 32'h10, 32'h0);
    idle();
    repeat (6) @(posedge clk);
    #1;

    resp_ready = 1'b0;
    send(1'b1, 32'h4, 32'h1111_2222);
    send(1'b1, 32'h8, 32'h3333_4444);
    send(1'b0, 32'h4, 32'h0);
    idle();
    pulse_reset();
    @(negedge clk);
    check("reset_flush", 64'({resp_valid, cmd_ready}), 64'({1'b0, 1'b1}));
    resp_ready = 1'b1;
    send(1'b0, 32'h4, 32'h0);
    idle();
    check_head("reg1_cleared", 1'b0, 32'h0, 8'd0);
    send(1'b0, 32'h0, 32'h0);
    idle();
    check_head("id_after_reset", 1'b0, ID, 8'd0);

    pulse_reset();
    send(1'b0, 32'h0, 32'h0);
    send(1'b0, 32'h4, 32'h0);
    send(1'b0, 32'h6, 32'h0);
    send(1'b1, 32'h8, 32'h7);
    idle();
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 32'h20, 32'h0);
    idle();
    if (STATS) check_head("stats_reads", 1'b0, 32'd3, 8'd0);
    else       check_head("stats_off_read", 1'b0, 32'd0, 8'd2);
    send(1'b0, 32'h24, 32'h0);
    idle();
    if (STATS) check_head("stats_writes", 1'b0, 32'd1, 8'd0);
    else       check_head("stats_off_write", 1'b0, 32'd0, 8'd2);
    send(1'b1, 32'h24, 32'h9);
    idle();
    if (STATS) check_head("stats_ro", 1'b1, 32'd0, 8'd3);
    else       check_head("stats_off_wr_range", 1'b1, 32'd0, 8'd2);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
